axi2apb_burst_split: RTL and testbench

//  AXI burst-to-single-beat splitter placed directly upstream of the axi2apb bridge.

---
 rtl/axi2apb_burst_split.sv | 179 +++++++++++++++++
 tb/tb_axi2apb_burst_split.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2apb_burst_split.sv
// Splits INCR AXI bursts into single-beat transactions for the downstream axi2apb
// bridge, merging per-beat B responses and regenerating RLAST on the read side.
module axi2apb_burst_split #(
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXI_ID_WIDTH-1:0]       s_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_awaddr,
  input  logic [7:0]                    s_awlen,
  input  logic [2:0]                    s_awsize,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                          s_wlast,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [AXI_ID_WIDTH-1:0]       s_bid,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  input  logic [AXI_ID_WIDTH-1:0]       s_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_araddr,
  input  logic [7:0]                    s_arlen,
  input  logic [2:0]                    s_arsize,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  output logic [AXI_ID_WIDTH-1:0]       s_rid,
  output logic [AXI_DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  output logic [AXI_ID_WIDTH-1:0]       m_awid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_awaddr,
  output logic [7:0]                    m_awlen,
  output logic [2:0]                    m_awsize,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                          m_wlast,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  input  logic [AXI_ID_WIDTH-1:0]       m_bid,
  input  logic [1:0]                    m_bresp,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  output logic [AXI_ID_WIDTH-1:0]       m_arid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [AXI_ID_WIDTH-1:0]       m_rid,
  input  logic [AXI_DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  input  logic                          m_rvalid,
  output logic                          m_rready
);

  localparam logic [1:0] W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;
  localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;

  logic [1:0]                w_state, w_next, r_state, r_next;
  logic [AXI_ID_WIDTH-1:0]   w_id, r_id;
  logic [AXI_ADDR_WIDTH-1:0] w_addr, r_addr;
  logic [7:0]                w_len, w_cnt, r_len, r_cnt;
  logic [2:0]                w_size, r_size;
  logic [1:0]                w_worst, w_merged;
  logic                      w_final, r_final;

  // Beat count comes from len alone; bridge IDs/RLAST and upstream WLAST are not needed.
  logic unused;
  assign unused = ^{s_wlast, m_bid, m_rid, m_rlast};

  assign w_final  = (w_cnt == w_len);
  assign r_final  = (r_cnt == r_len);
  assign w_merged = (m_bresp > w_worst) ? m_bresp : w_worst;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (s_awvalid && s_awready) w_next = W_ADDR;
      W_ADDR:  if (m_awready) w_next = W_DATA;
      W_DATA:  if (s_wvalid && m_wready) w_next = W_RESP;
      W_RESP:  if (m_bvalid && m_bready) w_next = w_final ? W_IDLE : W_ADDR;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s_arvalid && s_arready) r_next = R_ADDR;
      R_ADDR:  if (m_arready) r_next = R_DATA;
      R_DATA:  if (m_rvalid && s_rready) r_next = r_final ? R_IDLE : R_ADDR;
      default: r_next = R_IDLE;
    endcase
  end

  // State plus the registered handshake outputs, derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      s_awready <= 1'b0;
      s_arready <= 1'b0;
      m_awvalid <= 1'b0;
      m_arvalid <= 1'b0;
    end else begin
      w_state   <= w_next;
      r_state   <= r_next;
      s_awready <= (w_next == W_IDLE);
      s_arready <= (r_next == R_IDLE);
      m_awvalid <= (w_next == W_ADDR);
      m_arvalid <= (r_next == R_ADDR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_id <= '0; w_addr <= '0; w_len <= '0; w_size <= '0; w_cnt <= '0; w_worst <= 2'b00;
    end else if (w_state == W_IDLE && s_awvalid && s_awready) begin
      w_id <= s_awid; w_addr <= s_awaddr; w_len <= s_awlen; w_size <= s_awsize;
      w_cnt <= '0; w_worst <= 2'b00;
    end else if (w_state == W_RESP && m_bvalid && m_bready && !w_final) begin
      w_worst <= w_merged;
      w_cnt   <= w_cnt + 8'd1;
      w_addr  <= w_addr + (AXI_ADDR_WIDTH'(1) << w_size);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_size <= '0; r_cnt <= '0;
    end else if (r_state == R_IDLE && s_arvalid && s_arready) begin
      r_id <= s_arid; r_addr <= s_araddr; r_len <= s_arlen; r_size <= s_arsize;
      r_cnt <= '0;
    end else if (r_state == R_DATA && m_rvalid && s_rready && !r_final) begin
      r_cnt  <= r_cnt + 8'd1;
      r_addr <= r_addr + (AXI_ADDR_WIDTH'(1) << r_size);
    end
  end

  assign m_awid   = w_id;
  assign m_awaddr = w_addr;
  assign m_awlen  = 8'd0;
  assign m_awsize = w_size;

  assign m_wvalid = (w_state == W_DATA) && s_wvalid;
  assign s_wready = (w_state == W_DATA) && m_wready;
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;
  assign m_wlast  = 1'b1;

  // Intermediate B beats are absorbed; only the final one reaches upstream.
  assign m_bready = (w_state == W_RESP) && (w_final ? s_bready : 1'b1);
  assign s_bvalid = (w_state == W_RESP) && w_final && m_bvalid;
  assign s_bresp  = w_merged;
  assign s_bid    = w_id;

  assign m_arid   = r_id;
  assign m_araddr = r_addr;
  assign m_arlen  = 8'd0;
  assign m_arsize = r_size;

  assign s_rvalid = (r_state == R_DATA) && m_rvalid;
  assign m_rready = (r_state == R_DATA) && s_rready;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rid    = r_id;
  assign s_rlast  = r_final;

endmodule

// File: tb/tb_axi2apb_burst_split.sv
// Scoreboard bench for axi2apb_burst_split: random bursts, a bridge model and
// queue-based expectations built from the burst rules.
module tb_axi2apb_burst_split;
  localparam int unsigned IW = 6, AW = 32, DW = 64, SW = DW / 8;
  localparam int TMO = 200;

  typedef struct packed { logic [AW-1:0] addr; logic [IW-1:0] id; logic [2:0] size; } a_t;
  typedef struct packed { logic [DW-1:0] data; logic [SW-1:0] strb; } w_t;
  typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } b_t;
  typedef struct packed { logic [DW-1:0] data; logic [1:0] resp; } rb_t;
  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [IW-1:0] s_awid, s_bid, s_arid, s_rid, m_awid, m_bid, m_arid, m_rid;
  logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [7:0]    s_awlen, s_arlen, m_awlen, m_arlen;
  logic [2:0]    s_awsize, s_arsize, m_awsize, m_arsize;
  logic [DW-1:0] s_wdata, s_rdata, m_wdata, m_rdata;
  logic [SW-1:0] s_wstrb, m_wstrb;
  logic [1:0]    s_bresp, s_rresp, m_bresp, m_rresp;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

  axi2apb_burst_split dut (
    .clk(clk), .rst(rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int total = 0;
  int bad = 0;
  bit rr_random = 1'b1;
  logic [IW-1:0] last_awid, last_arid;

  a_t  exp_aw_q[$], exp_ar_q[$];
  w_t  exp_w_q[$];
  b_t  exp_b_q[$];
  r_t  exp_r_q[$];
  rb_t rbeat_q[$];
  logic [1:0] bresp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout_%s actual=stalled required=handshake", name);
  endtask

  function automatic logic [1:0] pick_resp();
    case ($urandom_range(0, 5))
      0:       return 2'b10;
      1:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Reference: beat i of a burst goes to addr + i*2^size (mod 2^32); B is the worst of all beats.
  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                          input logic [2:0] size, input int rmode, input int nw);
    logic [DW-1:0] wd [256];
    logic [SW-1:0] ws [256];
    logic [1:0] worst, r;
    int n;
    worst = 2'b00;
    for (int i = 0; i <= len; i++) begin
      exp_aw_q.push_back('{addr: addr + (AW'(i) << size), id: id, size: size});
      wd[i] = {$urandom, $urandom};
      ws[i] = SW'($urandom);
      exp_w_q.push_back('{data: wd[i], strb: ws[i]});
      case (rmode)
        1:       r = 2'b00;
        2:       r = (i == 0) ? 2'b10 : 2'b00;
        default: r = pick_resp();
      endcase
      bresp_q.push_back(r);
      if (r > worst) worst = r;
    end
    exp_b_q.push_back('{id: id, resp: worst});
    @(posedge clk); #1;
    s_awvalid = 1'b1; s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awsize = size;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_awready && n < TMO);
    if (!s_awready) timeout("s_awready");
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    for (int i = 0; i < nw; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      s_wvalid = 1'b1; s_wdata = wd[i]; s_wstrb = ws[i]; s_wlast = (i == len);
      n = 0;
      do begin @(negedge clk); n++; end while (!s_wready && n < TMO);
      if (!s_wready) timeout("s_wready");
      @(posedge clk); #1;
      s_wvalid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                         input logic [2:0] size);
    logic [DW-1:0] d;
    logic [1:0] rr;
    int n;
    for (int i = 0; i <= len; i++) begin
      exp_ar_q.push_back('{addr: addr + (AW'(i) << size), id: id, size: size});
      d = {$urandom, $urandom};
      rr = pick_resp();
      rbeat_q.push_back('{data: d, resp: rr});
      exp_r_q.push_back('{id: id, data: d, resp: rr, last: (i == len)});
    end
    @(posedge clk); #1;
    s_arvalid = 1'b1; s_arid = id; s_araddr = addr; s_arlen = 8'(len); s_arsize = size;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_arready && n < TMO);
    if (!s_arready) timeout("s_arready");
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_aw_q.size() + exp_w_q.size() + exp_b_q.size() + exp_ar_q.size() + exp_r_q.size()) != 0
           && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) timeout("drain");
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Random ready/back-pressure generation for bridge and upstream.
  initial begin
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_awready = ($urandom_range(0, 2) != 0);
      m_wready  = ($urandom_range(0, 2) != 0);
      m_arready = ($urandom_range(0, 2) != 0);
      s_bready  = ($urandom_range(0, 2) != 0);
      if (rr_random) s_rready = ($urandom_range(0, 2) != 0);
    end
  end

  // Bridge model, write side: one B per accepted W beat.
  initial begin
    int n;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_bid = '0;
    forever begin
      @(negedge clk);
      if (!rst && m_wvalid && m_wready) begin
        @(posedge clk); #1;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (!rst) begin
          m_bvalid = 1'b1;
          m_bid = last_awid;
          m_bresp = (bresp_q.size() != 0) ? bresp_q.pop_front() : 2'b01;
          n = 0;
          do begin @(negedge clk); n++; end while (!rst && !m_bready && n < TMO);
          if (!rst && !m_bready) timeout("m_bready");
          @(posedge clk); #1;
          m_bvalid = 1'b0;
        end
      end
    end
  end

  // Bridge model, read side: one R beat per accepted AR.
  initial begin
    int n;
    rb_t rb;
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rid = '0; m_rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && m_arvalid && m_arready) begin
        @(posedge clk); #1;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (!rst) begin
          rb = (rbeat_q.size() != 0) ? rbeat_q.pop_front() : '0;
          m_rvalid = 1'b1; m_rdata = rb.data; m_rresp = rb.resp; m_rid = last_arid; m_rlast = 1'b1;
          n = 0;
          do begin @(negedge clk); n++; end while (!rst && !m_rready && n < TMO);
          if (!rst && !m_rready) timeout("m_rready");
          @(posedge clk); #1;
          m_rvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every handshake the DUT takes part in against the queues.
  a_t ea, er;
  w_t ew;
  b_t eb;
  r_t eR;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_awvalid && m_awready) begin
        last_awid = m_awid;
        if (exp_aw_q.size() == 0) check("m_aw_unexpected", 128'(1), 128'(0));
        else begin
          ea = exp_aw_q.pop_front();
          check("m_awaddr", 128'(m_awaddr), 128'(ea.addr));
          check("m_awid", 128'(m_awid), 128'(ea.id));
          check("m_awsize", 128'(m_awsize), 128'(ea.size));
          check("m_awlen", 128'(m_awlen), 128'(0));
        end
      end
      if (m_wvalid && m_wready) begin
        if (exp_w_q.size() == 0) check("m_w_unexpected", 128'(1), 128'(0));
        else begin
          ew = exp_w_q.pop_front();
          check("m_wdata", 128'(m_wdata), 128'(ew.data));
          check("m_wstrb", 128'(m_wstrb), 128'(ew.strb));
          check("m_wlast", 128'(m_wlast), 128'(1));
        end
      end
      if (s_bvalid && s_bready) begin
        if (exp_b_q.size() == 0) check("s_b_unexpected", 128'(1), 128'(0));
        else begin
          eb = exp_b_q.pop_front();
          check("s_bid", 128'(s_bid), 128'(eb.id));
          check("s_bresp", 128'(s_bresp), 128'(eb.resp));
        end
      end
      if (m_arvalid && m_arready) begin
        last_arid = m_arid;
        if (exp_ar_q.size() == 0) check("m_ar_unexpected", 128'(1), 128'(0));
        else begin
          er = exp_ar_q.pop_front();
          check("m_araddr", 128'(m_araddr), 128'(er.addr));
          check("m_arid", 128'(m_arid), 128'(er.id));
          check("m_arsize", 128'(m_arsize), 128'(er.size));
          check("m_arlen", 128'(m_arlen), 128'(0));
        end
      end
      if (s_rvalid && s_rready) begin
        if (exp_r_q.size() == 0) check("s_r_unexpected", 128'(1), 128'(0));
        else begin
          eR = exp_r_q.pop_front();
          check("s_rid", 128'(s_rid), 128'(eR.id));
          check("s_rdata", 128'(s_rdata), 128'(eR.data));
          check("s_rresp", 128'(s_rresp), 128'(eR.resp));
          check("s_rlast", 128'(s_rlast), 128'(eR.last));
        end
      end
      if (m_rvalid && !s_rready) check("m_rready_stall", 128'(m_rready), 128'(0));
    end
  end

  task automatic check_idle_valids(input string tag);
    check({tag, "_s_bvalid"}, 128'(s_bvalid), 128'(0));
    check({tag, "_s_rvalid"}, 128'(s_rvalid), 128'(0));
    check({tag, "_m_awvalid"}, 128'(m_awvalid), 128'(0));
    check({tag, "_m_wvalid"}, 128'(m_wvalid), 128'(0));
    check({tag, "_m_arvalid"}, 128'(m_arvalid), 128'(0));
    check({tag, "_m_bready"}, 128'(m_bready), 128'(0));
    check({tag, "_m_rready"}, 128'(m_rready), 128'(0));
  endtask

  initial begin
    int n, len;
    logic [2:0] sz;
    rst = 1'b1;
    s_awvalid = 1'b0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
    s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_bready = 1'b0;
    s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_rready = 1'b0;
    last_awid = '0; last_arid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_valids("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_s_awready", 128'(s_awready), 128'(1));
    check("post_reset_s_arready", 128'(s_arready), 128'(1));

    do_write(6'd5, 32'h1000, 3, 3'd2, 1, 4);
    drain();
    do_write(6'd6, 32'h2000, 1, 3'd2, 2, 2);
    drain();

    rr_random = 1'b0;
    s_rready = 1'b0;
    do_read(6'd9, 32'h20, 2, 3'd3);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_rvalid && n < TMO);
    if (!m_rvalid) timeout("first_m_rvalid");
    repeat (4) begin @(posedge clk); #1; end
    s_rready = 1'b1;
    drain();
    rr_random = 1'b1;

    do_write(6'd3, 32'hFFFF_FFFC, 1, 3'd2, 0, 2);
    drain();

    fork
      do_write(6'd12, 32'h4000, 2, 3'd3, 0, 3);
      do_read(6'd13, 32'h8000, 2, 3'd2);
    join
    drain();

    // Reset while beat 2 of a 4-beat write awaits its B.
    do_write(6'd21, 32'h5000, 3, 3'd2, 0, 2);
    rst = 1'b1;
    @(negedge clk);
    check_idle_valids("mid_reset");
    repeat (2) @(posedge clk);
    exp_aw_q.delete(); exp_w_q.delete(); exp_b_q.delete(); bresp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_release_s_awready", 128'(s_awready), 128'(1));
    check("rst_release_s_bvalid", 128'(s_bvalid), 128'(0));
    do_write(6'd7, 32'h3000, 0, 3'd2, 0, 1);
    drain();

    for (int it = 0; it < 10; it++) begin
      len = $urandom_range(0, 7);
      sz = 3'($urandom_range(0, 3));
      fork
        do_write(6'($urandom), $urandom & ~((32'd1 << sz) - 32'd1), len, sz, 0, len + 1);
        do_read(6'($urandom), $urandom & ~((32'd1 << sz) - 32'd1), $urandom_range(0, 15), 3'($urandom_range(0, 3)));
      join
      drain();
    end
    do_read(6'd33, 32'h0001_0000, 255, 3'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
